// File: rtl/fg_pkg.sv
// Shared types for the function generator and its sweep controller.
// Holds the waveform select, sweep modes, sweep FSM states and a saturating duty helper.
package fg_pkg;

  typedef enum logic [1:0] {
    Sine     = 2'd0,
    Triangle = 2'd1,
    Square   = 2'd2,
    Pwm      = 2'd3
  } signal_t;

  typedef enum logic [1:0] {
    ModeOneshot = 2'd0,
    ModeRepeat  = 2'd1,
    ModeBounce  = 2'd2
  } sweep_mode_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDwell = 2'd1,
    StDone  = 2'd2
  } sweep_state_t;

  // Encoding 3 is reserved and behaves as a one-shot sweep.
  function automatic sweep_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return ModeRepeat;
      2'd2:    return ModeBounce;
      default: return ModeOneshot;
    endcase
  endfunction

  function automatic logic [7:0] duty_adv(input logic [7:0] d, input logic [7:0] s,
                                          input logic up);
    logic [8:0] t;
    if (up) begin
      t = {1'b0, d} + {1'b0, s};
      return t[8] ? 8'hFF : t[7:0];
    end else begin
      t = {1'b0, d} - {1'b0, s};
      return t[8] ? 8'h00 : t[7:0];
    end
  endfunction

endpackage

// File: rtl/fg_step_calc.sv
// Combinational next-point calculator: one step from cur toward tgt, clamped to tgt,
// with one extra bit of headroom so the result never wraps.
module fg_step_calc #(
  parameter int unsigned CntW = 32
) (
  input  logic [CntW-1:0] cur_i,
  input  logic [CntW-1:0] tgt_i,
  input  logic [CntW-1:0] step_i,
  input  logic            dir_up_i,
  output logic [CntW-1:0] nxt_o,
  output logic            at_tgt_o
);

  logic [CntW:0] sum;
  logic [CntW:0] diff;

  always_comb begin
    sum      = {1'b0, cur_i} + {1'b0, step_i};
    diff     = {1'b0, cur_i} - {1'b0, step_i};
    at_tgt_o = (cur_i == tgt_i);
    if (dir_up_i) begin
      nxt_o = (sum > {1'b0, tgt_i}) ? tgt_i : sum[CntW-1:0];
    end else begin
      // A set top bit means the subtraction went below zero.
      nxt_o = (diff[CntW] || (diff < {1'b0, tgt_i})) ? tgt_i : diff[CntW-1:0];
    end
  end

endmodule

// File: rtl/fg_sweep_ctrl.sv
// Frequency-sweep scheduler driving set_count/sig_type/duty_cycle of the generator core.
// Optional duty-cycle sweeping is enabled by defining DUTY_SWEEP_EN.
module fg_sweep_ctrl
  import fg_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cfg_start_cnt,
  input  logic [CNT_W-1:0]   cfg_stop_cnt,
  input  logic [CNT_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [1:0]         cfg_sig_type,
  input  logic [7:0]         cfg_duty,
`ifdef DUTY_SWEEP_EN
  input  logic [7:0]         cfg_duty_step,
`endif
  output logic [CNT_W-1:0]   set_count,
  output logic [1:0]         sig_type,
  output logic [7:0]         duty_cycle,
  output logic               retune,
  output logic               busy,
  output logic               done
);

  sweep_state_t       state_q, state_d;
  sweep_mode_t        mode_q, mode_d;
  signal_t            sig_type_q, sig_type_d;
  logic [CNT_W-1:0]   set_count_q, set_count_d;
  logic [CNT_W-1:0]   start_cnt_q, start_cnt_d;
  logic [CNT_W-1:0]   stop_cnt_q, stop_cnt_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [7:0]         duty_q, duty_d;
  logic               retune_q, retune_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tgt_is_stop_q, tgt_is_stop_d;
  logic               dir_up_q, dir_up_d;
`ifdef DUTY_SWEEP_EN
  logic [7:0]         duty_base_q, duty_base_d;
  logic [7:0]         duty_step_q, duty_step_d;
  logic               duty_up_q, duty_up_d;
`endif

  logic [CNT_W-1:0] tgt, other_tgt, nxt_fwd, nxt_rev;
  logic             at_tgt, unused_rev_at_tgt, point_end;

  assign tgt       = tgt_is_stop_q ? stop_cnt_q : start_cnt_q;
  assign other_tgt = tgt_is_stop_q ? start_cnt_q : stop_cnt_q;
  assign point_end = (dwell_cnt_q == (dwell_q - DWELL_W'(1)));

  fg_step_calc #(
    .CntW(CNT_W)
  ) u_calc_fwd (
    .cur_i   (set_count_q),
    .tgt_i   (tgt),
    .step_i  (step_q),
    .dir_up_i(dir_up_q),
    .nxt_o   (nxt_fwd),
    .at_tgt_o(at_tgt)
  );

  // Step taken at a bounce turnaround, toward the opposite endpoint.
  fg_step_calc #(
    .CntW(CNT_W)
  ) u_calc_rev (
    .cur_i   (set_count_q),
    .tgt_i   (other_tgt),
    .step_i  (step_q),
    .dir_up_i(~dir_up_q),
    .nxt_o   (nxt_rev),
    .at_tgt_o(unused_rev_at_tgt)
  );

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    sig_type_d    = sig_type_q;
    set_count_d   = set_count_q;
    start_cnt_d   = start_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    step_d        = step_q;
    dwell_d       = dwell_q;
    dwell_cnt_d   = dwell_cnt_q;
    duty_d        = duty_q;
    retune_d      = 1'b0;
    busy_d        = busy_q;
    done_d        = done_q;
    tgt_is_stop_d = tgt_is_stop_q;
    dir_up_d      = dir_up_q;
`ifdef DUTY_SWEEP_EN
    duty_base_d   = duty_base_q;
    duty_step_d   = duty_step_q;
    duty_up_d     = duty_up_q;
`endif

    if (abort) begin
      state_d     = StIdle;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      dwell_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d       = StDwell;
            mode_d        = decode_mode(cfg_mode);
            sig_type_d    = signal_t'(cfg_sig_type);
            duty_d        = cfg_duty;
            set_count_d   = cfg_start_cnt;
            start_cnt_d   = cfg_start_cnt;
            stop_cnt_d    = cfg_stop_cnt;
            step_d        = (cfg_step == '0) ? CNT_W'(1) : cfg_step;
            dwell_d       = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
            dwell_cnt_d   = '0;
            tgt_is_stop_d = 1'b1;
            dir_up_d      = (cfg_stop_cnt >= cfg_start_cnt);
            retune_d      = 1'b1;
            busy_d        = 1'b1;
            done_d        = 1'b0;
`ifdef DUTY_SWEEP_EN
            duty_base_d   = cfg_duty;
            duty_step_d   = cfg_duty_step;
            duty_up_d     = 1'b1;
`endif
          end
        end
        StDwell: begin
          if (!point_end) begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end else begin
            dwell_cnt_d = '0;
            if (!at_tgt) begin
              set_count_d = nxt_fwd;
              retune_d    = 1'b1;
`ifdef DUTY_SWEEP_EN
              duty_d      = duty_adv(duty_q, duty_step_q, duty_up_q);
`endif
            end else begin
              case (mode_q)
                ModeRepeat: begin
                  set_count_d = start_cnt_q;
                  retune_d    = 1'b1;
`ifdef DUTY_SWEEP_EN
                  duty_d      = duty_base_q;
`endif
                end
                ModeBounce: begin
                  set_count_d   = nxt_rev;
                  tgt_is_stop_d = ~tgt_is_stop_q;
                  dir_up_d      = ~dir_up_q;
                  retune_d      = 1'b1;
`ifdef DUTY_SWEEP_EN
                  duty_up_d     = ~duty_up_q;
                  duty_d        = duty_adv(duty_q, duty_step_q, ~duty_up_q);
`endif
                end
                default: begin
                  state_d = StDone;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                end
              endcase
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      mode_q        <= ModeOneshot;
      sig_type_q    <= Sine;
      set_count_q   <= '0;
      start_cnt_q   <= '0;
      stop_cnt_q    <= '0;
      step_q        <= '0;
      dwell_q       <= '0;
      dwell_cnt_q   <= '0;
      duty_q        <= '0;
      retune_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tgt_is_stop_q <= 1'b1;
      dir_up_q      <= 1'b1;
`ifdef DUTY_SWEEP_EN
      duty_base_q   <= '0;
      duty_step_q   <= '0;
      duty_up_q     <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      sig_type_q    <= sig_type_d;
      set_count_q   <= set_count_d;
      start_cnt_q   <= start_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      step_q        <= step_d;
      dwell_q       <= dwell_d;
      dwell_cnt_q   <= dwell_cnt_d;
      duty_q        <= duty_d;
      retune_q      <= retune_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tgt_is_stop_q <= tgt_is_stop_d;
      dir_up_q      <= dir_up_d;
`ifdef DUTY_SWEEP_EN
      duty_base_q   <= duty_base_d;
      duty_step_q   <= duty_step_d;
      duty_up_q     <= duty_up_d;
`endif
    end
  end

  assign set_count  = set_count_q;
  assign sig_type   = sig_type_q;
  assign duty_cycle = duty_q;
  assign retune     = retune_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fg_sweep_ctrl.sv
// Self-checking bench for fg_sweep_ctrl: table of sweeps scored against a queue of
// expected retune points, plus hand-written abort and asynchronous-reset sequences.
module tb_fg_sweep_ctrl;

  localparam int CNT_W   = 32;
  localparam int DWELL_W = 24;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [CNT_W-1:0]   cfg_start_cnt = '0;
  logic [CNT_W-1:0]   cfg_stop_cnt = '0;
  logic [CNT_W-1:0]   cfg_step = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [1:0]         cfg_mode = '0;
  logic [1:0]         cfg_sig_type = '0;
  logic [7:0]         cfg_duty = '0;
`ifdef DUTY_SWEEP_EN
  logic [7:0]         cfg_duty_step = '0;
`endif
  logic [CNT_W-1:0]   set_count;
  logic [1:0]         sig_type;
  logic [7:0]         duty_cycle;
  logic               retune, busy, done;

  always #5 clk = ~clk;

  fg_sweep_ctrl #(
    .CNT_W  (CNT_W),
    .DWELL_W(DWELL_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_start_cnt(cfg_start_cnt),
    .cfg_stop_cnt (cfg_stop_cnt),
    .cfg_step     (cfg_step),
    .cfg_dwell    (cfg_dwell),
    .cfg_mode     (cfg_mode),
    .cfg_sig_type (cfg_sig_type),
    .cfg_duty     (cfg_duty),
`ifdef DUTY_SWEEP_EN
    .cfg_duty_step(cfg_duty_step),
`endif
    .set_count    (set_count),
    .sig_type     (sig_type),
    .duty_cycle   (duty_cycle),
    .retune       (retune),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [31:0]      s;
    logic [31:0]      e;
    logic [31:0]      step;
    logic [23:0]      dwell;
    logic [1:0]       mode;
    logic [1:0]       sig;
    logic [7:0]       duty;
    int               n;
    logic [7:0][31:0] exp;
    logic             disturb;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    int          rel;
  } exp_t;

  vec_t vecs[11];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: DUT samples on posedge, outputs are scored on the following negedge.
  task automatic step_cycle();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (retune) begin
      chk("retune_pending", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("retune_value", set_count, e.val);
        chk("retune_cycle", cyc - base, e.rel);
      end
    end
  endtask

  function automatic vec_t mk(input logic [31:0] s, e, step, input logic [23:0] dwell,
                              input logic [1:0] mode, sig, input logic [7:0] duty,
                              input int n, input logic disturb,
                              input logic [31:0] e0, e1 = 0, e2 = 0, e3 = 0,
                              e4 = 0, e5 = 0, e6 = 0, e7 = 0);
    vec_t v;
    v.s = s; v.e = e; v.step = step; v.dwell = dwell; v.mode = mode;
    v.sig = sig; v.duty = duty; v.n = n; v.disturb = disturb;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp[4] = e4; v.exp[5] = e5; v.exp[6] = e6; v.exp[7] = e7;
    return v;
  endfunction

  task automatic drive_cfg(input vec_t v);
    cfg_start_cnt = v.s;
    cfg_stop_cnt  = v.e;
    cfg_step      = v.step;
    cfg_dwell     = v.dwell;
    cfg_mode      = v.mode;
    cfg_sig_type  = v.sig;
    cfg_duty      = v.duty;
  endtask

  task automatic push_exp(input vec_t v, input int cnt);
    exp_t e;
    int   d;
    d = (v.dwell == 0) ? 1 : int'(v.dwell);
    for (int i = 0; i < cnt; i++) begin
      e.val = v.exp[i];
      e.rel = i * d;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  d;
    logic busy_ok;
    d = (v.dwell == 0) ? 1 : int'(v.dwell);
    exp_q.delete();
    push_exp(v, v.n);
    drive_cfg(v);
    start = 1'b1;
    base  = cyc + 1;
    step_cycle();
    start = 1'b0;
    chk($sformatf("v%0d_busy_at_start", idx), busy, 1);
    chk($sformatf("v%0d_done_at_start", idx), done, 0);
    busy_ok = 1'b1;
    for (int r = 1; r < v.n * d; r++) begin
      if (v.disturb && r == 2) begin
        cfg_stop_cnt  = 32'd200;
        cfg_start_cnt = 32'd0;
        cfg_sig_type  = 2'd3;
        cfg_duty      = 8'hEE;
        start         = 1'b1;
      end
      step_cycle();
      start   = 1'b0;
      busy_ok = busy_ok & busy;
    end
    chk($sformatf("v%0d_busy_throughout", idx), busy_ok, 1);
    chk($sformatf("v%0d_retunes_missing", idx), exp_q.size(), 0);
    if (v.mode == 2'd0 || v.mode == 2'd3) begin
      step_cycle();
      chk($sformatf("v%0d_done", idx), done, 1);
      chk($sformatf("v%0d_busy_end", idx), busy, 0);
    end else begin
      abort = 1'b1;
      step_cycle();
      abort = 1'b0;
      chk($sformatf("v%0d_abort_busy", idx), busy, 0);
      chk($sformatf("v%0d_abort_done", idx), done, 0);
      chk($sformatf("v%0d_abort_retune", idx), retune, 0);
    end
    chk($sformatf("v%0d_final_count", idx), set_count, v.exp[v.n-1]);
    chk($sformatf("v%0d_sig_type", idx), sig_type, v.sig);
    chk($sformatf("v%0d_duty", idx), duty_cycle, v.duty);
  endtask

  initial begin
    //         start         stop          step          dwell mode sig duty  n  dist expected points
    vecs[0]  = mk(32'd100,   32'd130,      32'd10,       24'd4, 2'd0, 2'd1, 8'h40, 4, 1'b0,
                  32'd100, 32'd110, 32'd120, 32'd130);
    vecs[1]  = mk(32'd50,    32'd7,        32'd20,       24'd1, 2'd0, 2'd2, 8'h10, 4, 1'b0,
                  32'd50, 32'd30, 32'd10, 32'd7);
    vecs[2]  = mk(32'd0,     32'd2,        32'd1,        24'd2, 2'd2, 2'd0, 8'h00, 7, 1'b0,
                  32'd0, 32'd1, 32'd2, 32'd1, 32'd0, 32'd1, 32'd2);
    vecs[3]  = mk(32'd5,     32'd7,        32'd0,        24'd0, 2'd0, 2'd3, 8'h80, 3, 1'b0,
                  32'd5, 32'd6, 32'd7);
    vecs[4]  = mk(32'd3,     32'd5,        32'd2,        24'd3, 2'd1, 2'd1, 8'h22, 5, 1'b0,
                  32'd3, 32'd5, 32'd3, 32'd5, 32'd3);
    vecs[5]  = mk(32'd9,     32'd9,        32'd4,        24'd2, 2'd3, 2'd2, 8'h33, 1, 1'b0,
                  32'd9);
    vecs[6]  = mk(32'd9,     32'd9,        32'd1,        24'd2, 2'd2, 2'd3, 8'h44, 3, 1'b0,
                  32'd9, 32'd9, 32'd9);
    vecs[7]  = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10,  24'd1, 2'd0, 2'd1, 8'h55, 2, 1'b0,
                  32'hFFFF_FFF0, 32'hFFFF_FFFF);
    vecs[8]  = mk(32'd5,     32'd0,        32'hFFFF_FFFF, 24'd1, 2'd0, 2'd2, 8'h66, 2, 1'b0,
                  32'd5, 32'd0);
    vecs[9]  = mk(32'd1,     32'd8,        32'd5,        24'd1, 2'd2, 2'd0, 8'h77, 6, 1'b0,
                  32'd1, 32'd6, 32'd8, 32'd3, 32'd1, 32'd6);
    vecs[10] = mk(32'd100,   32'd130,      32'd10,       24'd4, 2'd0, 2'd1, 8'h40, 4, 1'b1,
                  32'd100, 32'd110, 32'd120, 32'd130);

    // Power-on reset and reset-state outputs.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_set_count", set_count, 0);
    chk("reset_sig_type", sig_type, 0);
    chk("reset_duty", duty_cycle, 0);
    chk("reset_retune", retune, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Abort in the second point, with start asserted alongside it.
    exp_q.delete();
    push_exp(vecs[0], 2);
    drive_cfg(vecs[0]);
    start = 1'b1;
    base  = cyc + 1;
    step_cycle();
    start = 1'b0;
    for (int r = 1; r <= 5; r++) step_cycle();
    abort = 1'b1;
    start = 1'b1;
    step_cycle();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_retune", retune, 0);
    chk("abort_set_count", set_count, 32'd110);
    for (int r = 0; r < 8; r++) step_cycle();
    chk("abort_hold_count", set_count, 32'd110);
    chk("abort_hold_busy", busy, 0);
    chk("abort_retunes_missing", exp_q.size(), 0);

    // Asynchronous reset in the middle of a sweep.
    exp_q.delete();
    push_exp(vecs[4], 2);
    drive_cfg(vecs[4]);
    start = 1'b1;
    base  = cyc + 1;
    step_cycle();
    start = 1'b0;
    for (int r = 1; r <= 4; r++) step_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_set_count", set_count, 0);
    chk("areset_sig_type", sig_type, 0);
    chk("areset_duty", duty_cycle, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_retune", retune, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();

    // Recovery after reset.
    run_vec(vecs[3], 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
